// File: rtl/xgriscv_muldiv.sv
// ============================================================================
// Module   : xgriscv_muldiv
// Purpose  : Iterative RV32M multiply/divide unit with valid/ready handshakes.
//            Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xgriscv_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_lastCnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_minInt  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state, w_stateNext;
  logic [2:0]         r_op;
  logic               r_negQ, r_negR;
  logic [WIDTH-1:0]   r_addend;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept, w_signedA, w_signedB, w_sA, w_sB;
  logic               w_divZero, w_ovf, w_bypass;
  logic [WIDTH-1:0]   w_magA, w_magB, w_bypassRes;
  logic [WIDTH:0]     w_mulSum, w_divShift;
  logic [WIDTH-1:0]   w_divDiff;
  logic               w_divGe;
  logic [WIDTH-1:0]   w_hiNext, w_loNext, w_calcRes;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic               w_resLoad;
  logic [WIDTH-1:0]   w_resNext;

  // Sign-correct a 2*WIDTH product magnitude and pick the low or high half.
  function automatic logic [WIDTH-1:0] mulSel(input logic [2*WIDTH-1:0] prod,
                                              input logic neg, input logic [1:0] sel);
    logic [2*WIDTH-1:0] s;
    s = neg ? -prod : prod;
    return (sel == 2'b00) ? s[WIDTH-1:0] : s[2*WIDTH-1:WIDTH];
  endfunction

  assign op_ready  = (r_state == ST_IDLE) && !reset;
  assign res_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign result    = r_result;

  assign w_accept  = op_valid && op_ready && !flush;
  // MUL low half is sign-agnostic, so it runs on raw unsigned operands.
  assign w_signedA = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_signedB = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_sA      = w_signedA && opA[WIDTH-1];
  assign w_sB      = w_signedB && opB[WIDTH-1];
  assign w_magA    = w_sA ? -opA : opA;
  assign w_magB    = w_sB ? -opB : opB;

  assign w_divZero   = op[2] && (opB == '0);
  assign w_ovf       = op[2] && !op[0] && (opA == c_minInt) && (&opB);
  assign w_bypass    = w_divZero || w_ovf;
  assign w_bypassRes = w_divZero ? (op[1] ? opA : '1) : (op[1] ? '0 : opA);

  // Shift-add multiply: {hi,lo} holds partial product with the multiplier in lo.
  // Restoring divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_addend} : '0);
  assign w_divShift = {r_hi, r_lo[WIDTH-1]};
  assign w_divGe    = (w_divShift >= {1'b0, r_addend});
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_addend;

  always_comb begin
    w_hiNext = r_hi;
    w_loNext = r_lo;
    if (r_op[2]) begin
      w_hiNext = w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
      w_loNext = {r_lo[WIDTH-2:0], w_divGe};
    end else begin
      w_hiNext = w_mulSum[WIDTH:1];
      w_loNext = {w_mulSum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_quo     = r_negQ ? -w_loNext : w_loNext;
  assign w_rem     = r_negR ? -w_hiNext : w_hiNext;
  assign w_calcRes = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                             : mulSel({w_hiNext, w_loNext}, r_negQ, r_op[1:0]);

  always_comb begin
    w_stateNext = r_state;
    w_resLoad   = 1'b0;
    w_resNext   = w_calcRes;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bypass) begin
            w_stateNext = ST_DONE;
            w_resLoad   = 1'b1;
            w_resNext   = w_bypassRes;
          end else begin
            w_stateNext = ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[2]) begin
              w_stateNext = ST_DONE;
              w_resLoad   = 1'b1;
              w_resNext   = mulSel({{WIDTH{1'b0}}, w_magA} * {{WIDTH{1'b0}}, w_magB},
                                   w_sA ^ w_sB, op[1:0]);
            end
`endif
          end
        end
      end
      ST_CALC: begin
        if (r_cnt == c_lastCnt) begin
          w_stateNext = ST_DONE;
          w_resLoad   = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
    if (flush) begin
      w_stateNext = ST_IDLE;
      w_resLoad   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_addend <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_op     <= op;
        r_negQ   <= w_sA ^ w_sB;
        r_negR   <= w_sA;
        r_addend <= op[2] ? w_magB : w_magA;
        r_hi     <= '0;
        r_lo     <= op[2] ? w_magA : w_magB;
        r_cnt    <= '0;
      end else if (r_state == ST_CALC) begin
        r_hi  <= w_hiNext;
        r_lo  <= w_loNext;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_resLoad) r_result <= w_resNext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xgriscv_muldiv.sv
// ============================================================================
// Module   : tb_xgriscv_muldiv
// Purpose  : Scoreboard bench for xgriscv_muldiv (latency, arithmetic, flush).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xgriscv_muldiv;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset, op_valid, flush, res_ready;
  logic             op_ready, res_valid, busy;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA, opB, result;

  int nErr = 0;
  int nChk = 0;
  logic [31:0] expQ[$];

  xgriscv_muldiv #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .opA(opA), .opB(opB), .flush(flush), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin r = sa * sb; p = r; return p[63:32]; end
      3'd2: begin r = sa * ub; p = r; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = sa / sb; p = r; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        r = sa % sb; p = r; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0)) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return WIDTH + 1;
  endfunction

  // Issue one request, check latency and result, optionally hold backpressure.
  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    int w, lat, el;
    logic [31:0] e;
    @(negedge clk);
    w = 0;
    while (!op_ready && w < 100) begin @(negedge clk); w++; end
    op_valid = 1'b1; op = o; opA = a; opB = b;
    expQ.push_back(model(o, a, b));
    el = expLat(o, a, b);
    @(posedge clk); #1;
    op_valid = 1'b0; opA = $urandom; opB = $urandom; op = 3'($urandom_range(0, 7));
    lat = 1;
    while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk($sformatf("lat op%0d", o), lat, el);
    e = expQ.pop_front();
    if (!res_valid) return;
    chk($sformatf("res op%0d %h,%h", o, a, b), result, e);
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold valid", {31'b0, res_valid}, 1);
      chk("hold result", result, e);
      chk("hold op_ready", {31'b0, op_ready}, 0);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post valid", {31'b0, res_valid}, 0);
    chk("post ready", {31'b0, op_ready}, 1);
  endtask

  initial begin
    int pulses;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    op = '0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", {31'b0, res_valid}, 0);
    chk("rst result", result, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst ready", {31'b0, op_ready}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("ready after rst", {31'b0, op_ready}, 1);

    doOp(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    doOp(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    doOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    doOp(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    doOp(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    doOp(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    doOp(3'd5, 32'd100, 32'd7, 0);
    doOp(3'd7, 32'd100, 32'd7, 0);
    doOp(3'd5, 32'd5, 32'd0, 0);
    doOp(3'd6, 32'd5, 32'd0, 0);
    doOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    doOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    doOp(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5);
    doOp(3'd4, 32'h8000_0000, 32'd0, 5);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 6 == 5) ? 32'd0 : ((i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom);
      doOp(ro, ra, rb, 0);
    end

    // Flush a divide at CALC cycle 10; no result may appear.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; opA = 32'd1000; opB = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 0);
    chk("flush ready", {31'b0, op_ready}, 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("flush no result", pulses, 0);
    doOp(3'd0, 32'd3, 32'd4, 0);

    // Flush alongside a request discards it.
    @(negedge clk);
    op_valid = 1'b1; flush = 1'b1; op = 3'd5; opA = 32'd9; opB = 32'd0;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    chk("flush accept busy", {31'b0, busy}, 0);

    // Reset in the middle of a calculation.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd7; opA = 32'd77; opB = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst valid", {31'b0, res_valid}, 0);
    chk("midrst result", result, 0);
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst ready", {31'b0, op_ready}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst ready after", {31'b0, op_ready}, 1);
    doOp(3'd7, 32'd77, 32'd5, 0);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule

`default_nettype wire
